// File: rtl/i2c_target_as5600_pkg.sv
// Shared definitions for the AS5600-compatible I2C target: FSM states,
// register addresses and the read-side register mux.
package i2c_target_as5600_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h36;

  localparam logic [7:0] REG_CONF_H = 8'h07;
  localparam logic [7:0] REG_CONF_L = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0B;
  localparam logic [7:0] REG_RAW_H  = 8'h0C;
  localparam logic [7:0] REG_RAW_L  = 8'h0D;
  localparam logic [7:0] REG_ANG_H  = 8'h0E;
  localparam logic [7:0] REG_ANG_L  = 8'h0F;

  localparam int MD_BIT = 5;

  // Read mux: the angle argument is the coherent shadow copy, not the live input.
  function automatic logic [7:0] rd_reg(input logic [7:0]  addr,
                                        input logic [13:0] conf,
                                        input logic [11:0] angle,
                                        input logic        md);
    logic [7:0] r;
    r = 8'h00;
    case (addr)
      REG_CONF_H:           r = {2'b00, conf[13:8]};
      REG_CONF_L:           r = conf[7:0];
      REG_STATUS:           r[MD_BIT] = md;
      REG_RAW_H, REG_ANG_H: r = {4'h0, angle[11:8]};
      REG_RAW_L, REG_ANG_L: r = angle[7:0];
      default:              r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_target_as5600_in_filter.sv
// Pad-line conditioner: 2-flop synchronizer, FILT_LEN-sample glitch filter
// and one-cycle edge strobes derived from the filtered level.
module i2c_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_in,
  output logic line_filt,
  output logic rise,
  output logic fall
);

  logic       sync_p0;
  logic       sync_p1;
  logic [2:0] cnt;
  logic       filt_d;

  // Two-flop synchronizer; idles high like an undriven I2C line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
    end
  end

  // Filtered level flips only after FILT_LEN consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_filt <= 1'b1;
      cnt       <= 3'd0;
    end else if (sync_p1 != line_filt) begin
      if (cnt == 3'(FILT_LEN - 1)) begin
        line_filt <= sync_p1;
        cnt       <= 3'd0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end else begin
      cnt <= 3'd0;
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) filt_d <= 1'b1;
    else          filt_d <= line_filt;
  end

  assign rise = line_filt & ~filt_d;
  assign fall = ~line_filt & filt_d;

endmodule

// File: rtl/i2c_target_as5600.sv
// AS5600 register-interface emulation as an I2C target: serves a coherent
// 12-bit angle snapshot, STATUS.MD, and a writable 14-bit CONF register.
module i2c_target_as5600
  import i2c_target_as5600_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int         FILT_LEN = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [11:0] raw_angle,
  input  logic        magnet_ok,
  output logic [13:0] conf,
  output logic        busy
);

  logic scl_filt, scl_rise, scl_fall;
  logic sda_filt, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filter (
    .clock(clock), .reset_n(reset_n), .line_in(scl_in),
    .line_filt(scl_filt), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filter (
    .clock(clock), .reset_n(reset_n), .line_in(sda_in),
    .line_filt(sda_filt), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t  state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  ptr, ptr_nxt;
  logic [13:0] conf_nxt;
  logic        oe_nxt, busy_nxt;
  logic        fall_d;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  tx, tx_nxt;
  logic [11:0] shadow, shadow_nxt;
  logic [7:0]  byte_in;

  // Control state: FSM, counters, pointer, CONF and the SDA driver.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      ptr     <= 8'h00;
      conf    <= 14'h0000;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      fall_d  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      ptr     <= ptr_nxt;
      conf    <= conf_nxt;
      sda_oe  <= oe_nxt;
      busy    <= busy_nxt;
      fall_d  <= scl_fall;
    end
  end

  // Data registers: shift-in byte, transmit byte, angle snapshot.
  always_ff @(posedge clock) begin
    shift  <= shift_nxt;
    tx     <= tx_nxt;
    shadow <= shadow_nxt;
  end

  // Next-state logic: STOP/START first, then bit handling on SCL rise,
  // then SDA drive update on the cycle after SCL fall.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    ptr_nxt     = ptr;
    conf_nxt    = conf;
    oe_nxt      = sda_oe;
    busy_nxt    = busy;
    shift_nxt   = shift;
    tx_nxt      = tx;
    shadow_nxt  = shadow;
    byte_in     = {shift[6:0], sda_filt};

    if (sda_rise && scl_filt) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else if (sda_fall && scl_filt) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 3'd0;
      oe_nxt      = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      if (scl_rise) begin
        case (state)
          ST_ADDR: begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state_nxt = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IDLE;
          end
          ST_ADDR_ACK: begin
            bit_cnt_nxt = 3'd0;
            if (shift[0]) begin
              shadow_nxt = raw_angle;
              tx_nxt     = rd_reg(ptr, conf, raw_angle, magnet_ok);
              state_nxt  = ST_RD_DATA;
            end else begin
              state_nxt = ST_REG_PTR;
            end
          end
          ST_REG_PTR: begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr_nxt   = byte_in;
              state_nxt = ST_PTR_ACK;
            end
          end
          ST_PTR_ACK, ST_WR_ACK: begin
            bit_cnt_nxt = 3'd0;
            state_nxt   = ST_WR_DATA;
          end
          ST_WR_DATA: begin
            shift_nxt   = byte_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (ptr == REG_CONF_H) conf_nxt[13:8] = byte_in[5:0];
              if (ptr == REG_CONF_L) conf_nxt[7:0]  = byte_in;
              ptr_nxt   = ptr + 8'd1;
              state_nxt = ST_WR_ACK;
            end
          end
          ST_RD_DATA: begin
            tx_nxt      = {tx[6:0], 1'b0};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = ST_RD_ACK;
          end
          ST_RD_ACK: begin
            if (!sda_filt) begin
              ptr_nxt     = ptr + 8'd1;
              tx_nxt      = rd_reg(ptr + 8'd1, conf, shadow, magnet_ok);
              bit_cnt_nxt = 3'd0;
              state_nxt   = ST_RD_DATA;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
      if (fall_d) begin
        case (state)
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: oe_nxt = 1'b1;
          ST_RD_DATA:                         oe_nxt = ~tx[7];
          default:                            oe_nxt = 1'b0;
        endcase
      end
    end
  end

endmodule
